qoi_enc_sequencer: RTL

- Bus-master controller that drives the QOI encoder peripheral's byte-wide register port (cs/we/addr/data) on behalf of the host.
- Loads the pixel count, starts the encoder, and feeds 32-bit pixels from a valid/ready stream as four byte writes each.
- Drains encoded bytes to a byte-wide valid/ready sink.
- Sits between the pixel source / output buffer and the encoder, replacing 6502 software polling.

---
 rtl/qoi_enc_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/qoi_enc_sequencer.sv
// QOI encoder bus-master sequencer: programs the pixel count, starts the
// encoder, feeds 32-bit pixels as four byte writes and drains encoded bytes
// to a valid/ready sink, polling the encoder status register in between.
module qoi_enc_sequencer #(
   parameter int SIZE_W  = 30,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_start,
   input  logic [SIZE_W-1:0] cmd_size,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       bytes_out,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [31:0]       pix_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              enc_rst,
   output logic              enc_cs,
   output logic              enc_we,
   output logic [2:0]        enc_addr,
   output logic [7:0]        enc_wdata,
   input  logic [7:0]        enc_rdata
);

   localparam int PollW = $clog2(TIMEOUT + 1);
   localparam logic [PollW-1:0] PollLast = PollW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      StIdle, StInit, StCfg, StPoll, StPixWait, StPixWr, StCapture, StOut, StFinish
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [SIZE_W-1:0] pixSent_q, pixSent_d;
   logic [PollW-1:0]  pollCnt_q, pollCnt_d;
   logic [31:0]       pix_q, pix_d;
   logic [7:0]        outData_q, outData_d;
   logic              outValid_q, outValid_d;
   logic [31:0]       bytesOut_q, bytesOut_d;
   logic              error_q, error_d;
   logic              done_q, done_d;
   logic [31:0]       sizeExt;

   assign sizeExt   = 32'(size_q);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign error     = error_q;
   assign bytes_out = bytesOut_q;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;

   // Next-state logic and encoder bus drive; the bus is idle unless a state
   // explicitly touches the encoder, so address 0 is only read in CAPTURE.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      size_d     = size_q;
      pixSent_d  = pixSent_q;
      pollCnt_d  = pollCnt_q;
      pix_d      = pix_q;
      outData_d  = outData_q;
      outValid_d = outValid_q;
      bytesOut_d = bytesOut_q;
      error_d    = error_q;
      done_d     = 1'b0;
      enc_rst    = 1'b0;
      enc_cs     = 1'b0;
      enc_we     = 1'b0;
      enc_addr   = 3'd0;
      enc_wdata  = 8'd0;
      pix_ready  = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_start) begin
               size_d     = cmd_size;
               pixSent_d  = '0;
               bytesOut_d = '0;
               pollCnt_d  = '0;
               error_d    = 1'b0;
               idx_d      = 3'd0;
               state_d    = StInit;
            end
         end
         StInit: begin
            enc_rst = 1'b1;
            idx_d   = 3'd0;
            state_d = StCfg;
         end
         StCfg: begin
            enc_cs = 1'b1;
            enc_we = 1'b1;
            if (idx_q == 3'd4) begin
               enc_addr  = 3'd3;
               enc_wdata = 8'h80;
               idx_d     = 3'd0;
               state_d   = StPoll;
            end else begin
               enc_addr = 3'd4 + idx_q;
               case (idx_q[1:0])
                  2'd0:    enc_wdata = sizeExt[7:0];
                  2'd1:    enc_wdata = sizeExt[15:8];
                  2'd2:    enc_wdata = sizeExt[23:16];
                  default: enc_wdata = sizeExt[31:24] & 8'h3F;
               endcase
               idx_d = idx_q + 3'd1;
            end
         end
         StPoll: begin
            enc_cs   = 1'b1;
            enc_addr = 3'd3;
            if (enc_rdata[1]) begin
               pollCnt_d = '0;
               state_d   = StCapture;
            end else if (enc_rdata[0]) begin
               pollCnt_d = '0;
               state_d   = (pixSent_q < size_q) ? StPixWait : StFinish;
            end else if (pollCnt_q == PollLast) begin
               pollCnt_d = '0;
               error_d   = 1'b1;
               state_d   = StFinish;
            end else begin
               pollCnt_d = pollCnt_q + 1'b1;
            end
         end
         StPixWait: begin
            pix_ready = pix_valid;
            if (pix_valid) begin
               pix_d   = pix_data;
               idx_d   = 3'd0;
               state_d = StPixWr;
            end
         end
         StPixWr: begin
            enc_cs   = 1'b1;
            enc_we   = 1'b1;
            enc_addr = 3'd0;
            case (idx_q[1:0])
               2'd0:    enc_wdata = pix_q[7:0];
               2'd1:    enc_wdata = pix_q[15:8];
               2'd2:    enc_wdata = pix_q[23:16];
               default: enc_wdata = pix_q[31:24];
            endcase
            if (idx_q == 3'd3) begin
               idx_d     = 3'd0;
               pixSent_d = pixSent_q + 1'b1;
               state_d   = StPoll;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         StCapture: begin
            enc_cs     = 1'b1;
            enc_addr   = 3'd0;
            outData_d  = enc_rdata;
            outValid_d = 1'b1;
            state_d    = StOut;
         end
         StOut: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               if (bytesOut_q != 32'hFFFF_FFFF) begin
                  bytesOut_d = bytesOut_q + 32'd1;
               end
               state_d = StPoll;
            end
         end
         StFinish: begin
            enc_cs    = 1'b1;
            enc_we    = 1'b1;
            enc_addr  = 3'd3;
            enc_wdata = 8'h00;
            done_d    = ~error_q;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= 3'd0;
         size_q     <= '0;
         pixSent_q  <= '0;
         pollCnt_q  <= '0;
         pix_q      <= 32'd0;
         outData_q  <= 8'd0;
         outValid_q <= 1'b0;
         bytesOut_q <= 32'd0;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         size_q     <= size_d;
         pixSent_q  <= pixSent_d;
         pollCnt_q  <= pollCnt_d;
         pix_q      <= pix_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
         bytesOut_q <= bytesOut_d;
         error_q    <= error_d;
         done_q     <= done_d;
      end
   end

endmodule
